maxpool2x2_reader: RTL and testbench

- Downstream consumer of the banked feature-map RAM in the first max-pool stage.
- One RAM bank per channel; all banks hold the same spatial map layout.
- The block scans the stored IN_H x IN_W map in 2x2, stride-2 windows. It reads all channel banks in parallel and emits one pooled vector of NUM_CH signed values per output pixel on a valid/ready stream to the next layer.

---
 rtl/maxpool_pkg.sv | 23 ++
 rtl/max_acc_lane.sv | 30 +++
 rtl/maxpool2x2_reader.sv | 148 ++++++++++++++
 tb/tb_maxpool2x2_reader.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool_pkg.sv
// Shared types and defaults for the 2x2 max-pool reader and its lanes.
package maxpool_pkg;

    localparam int D_WID_DEF = 20;
    localparam int A_WID_DEF = 7;

    typedef logic signed [D_WID_DEF-1:0] data_t;
    typedef logic        [A_WID_DEF-1:0] addr_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        DRAIN = 3'd2,
        OUT   = 3'd3,
        FIN   = 3'd4
    } state_t;

    // Index width that never collapses to zero bits for a single-entry axis.
    function automatic int idx_width(input int n);
        return ($clog2(n) < 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/max_acc_lane.sv
// One channel's running signed maximum over a 2x2 window.
module max_acc_lane
    import maxpool_pkg::*;
#(
    parameter int D_WID = D_WID_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic                    update_i,
    input  logic signed [D_WID-1:0] sample_i,
    output logic signed [D_WID-1:0] acc_o
);

    logic signed [D_WID-1:0] acc_q;

    // First sample of a window loads outright; later samples replace only if strictly larger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (load_i) begin
            acc_q <= sample_i;
        end else if (update_i && (sample_i > acc_q)) begin
            acc_q <= sample_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/maxpool2x2_reader.sv
// Scans a banked feature map in 2x2 stride-2 windows and streams per-channel maxima.
module maxpool2x2_reader
    import maxpool_pkg::*;
#(
    parameter int  NUM_CH = 128,
    parameter int  A_WID  = A_WID_DEF,
    parameter int  D_WID  = D_WID_DEF,
    parameter int  IN_W   = 10,
    parameter int  IN_H   = 10,
    localparam int OUT_W  = IN_W / 2,
    localparam int OUT_H  = IN_H / 2,
    localparam int ROW_W  = idx_width(OUT_H),
    localparam int COL_W  = idx_width(OUT_W)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [NUM_CH-1:0]       ram_ena,
    output logic [NUM_CH-1:0]       ram_we,
    output logic [A_WID-1:0]        ram_addr [NUM_CH],
    input  logic signed [D_WID-1:0] ram_dout [NUM_CH],
    output logic                    m_valid,
    input  logic                    m_ready,
    output logic signed [D_WID-1:0] m_data [NUM_CH],
    output logic [ROW_W-1:0]        m_row,
    output logic [COL_W-1:0]        m_col
);

    state_t           state_q, state_d;
    logic [1:0]       k_q, k_d;
    logic [ROW_W-1:0] r_q, r_d;
    logic [COL_W-1:0] c_q, c_d;
    logic             cap_vld_q;
    logic             cap_first_q;

    logic             issuing;
    logic             last_col;
    logic             last_row;
    logic [A_WID-1:0] row_a;
    logic [A_WID-1:0] col_a;
    logic [A_WID-1:0] addr_w;

    assign issuing  = (state_q == ISSUE);
    assign last_col = (c_q == COL_W'(OUT_W - 1));
    assign last_row = (r_q == ROW_W'(OUT_H - 1));

    // Window origin (2r,2c) plus the k-th corner, flattened row-major.
    assign row_a  = (A_WID'(r_q) << 1) + A_WID'(k_q[1]);
    assign col_a  = (A_WID'(c_q) << 1) + A_WID'(k_q[0]);
    assign addr_w = row_a * A_WID'(IN_W) + col_a;

    // Next-state logic for the scan FSM and its window/corner counters.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        r_d     = r_q;
        c_d     = c_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ISSUE;
                    k_d     = '0;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            ISSUE: begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) state_d = DRAIN;
            end
            DRAIN: state_d = OUT;
            OUT: begin
                if (m_ready) begin
                    k_d = '0;
                    if (last_col) begin
                        c_d = '0;
                        if (last_row) begin
                            r_d     = '0;
                            state_d = FIN;
                        end else begin
                            r_d     = r_q + 1'b1;
                            state_d = ISSUE;
                        end
                    end else begin
                        c_d     = c_q + 1'b1;
                        state_d = ISSUE;
                    end
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers; reset mid-pass simply abandons the scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            r_q     <= r_d;
            c_q     <= c_d;
        end
    end

    // RAM data lags the read by one cycle, so remember which corner is arriving.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_vld_q   <= 1'b0;
            cap_first_q <= 1'b0;
        end else begin
            cap_vld_q   <= issuing;
            cap_first_q <= (k_q == 2'd0);
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_lane
            assign ram_ena[gi]  = issuing;
            assign ram_we[gi]   = 1'b0;
            assign ram_addr[gi] = issuing ? addr_w : '0;

            max_acc_lane #(
                .D_WID (D_WID)
            ) u_lane (
                .clk      (clk),
                .rst_n    (rst_n),
                .load_i   (cap_vld_q && cap_first_q),
                .update_i (cap_vld_q && !cap_first_q),
                .sample_i (ram_dout[gi]),
                .acc_o    (m_data[gi])
            );
        end
    endgenerate

    assign busy    = (state_q == ISSUE) || (state_q == DRAIN) || (state_q == OUT);
    assign done    = (state_q == FIN);
    assign m_valid = (state_q == OUT);
    assign m_row   = r_q;
    assign m_col   = c_q;

endmodule

// File: tb/tb_maxpool2x2_reader.sv
// Directed bench for maxpool2x2_reader: a 2-channel 4x4 instance plus an odd 5x3 instance.
module tb_maxpool2x2_reader;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic m_ready = 1'b1;

    logic              busy, done, m_valid;
    logic [1:0]        ram_ena, ram_we;
    logic [6:0]        ram_addr [2];
    logic signed [19:0] ram_dout [2];
    logic signed [19:0] m_data [2];
    logic [0:0]        m_row, m_col;

    logic              start2 = 1'b0;
    logic              m_ready2 = 1'b1;
    logic              busy2, done2, m_valid2;
    logic [0:0]        ram_ena2, ram_we2;
    logic [6:0]        ram_addr2 [1];
    logic signed [19:0] ram_dout2 [1];
    logic signed [19:0] m_data2 [1];
    logic [0:0]        m_row2, m_col2;

    logic signed [19:0] mem [2][128];
    logic signed [19:0] mem2 [128];

    int pass_cnt = 0;
    int total_cnt = 0;

    int n_out, done_seen, done_n, first_v_n;
    logic signed [19:0] o_d0 [8];
    logic signed [19:0] o_d1 [8];
    logic [0:0] o_row [8];
    logic [0:0] o_col [8];

    int exp0 [4] = '{5, 7, 13, 15};
    int exp1 [4] = '{0, -2, -8, -10};
    int exp_r [4] = '{0, 0, 1, 1};
    int exp_c [4] = '{0, 1, 0, 1};

    always #5 clk = ~clk;

    maxpool2x2_reader #(
        .NUM_CH (2), .A_WID (7), .D_WID (20), .IN_W (4), .IN_H (4)
    ) u_dut (
        .clk (clk), .rst_n (rst_n), .start (start), .busy (busy), .done (done),
        .ram_ena (ram_ena), .ram_we (ram_we), .ram_addr (ram_addr), .ram_dout (ram_dout),
        .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data), .m_row (m_row), .m_col (m_col)
    );

    maxpool2x2_reader #(
        .NUM_CH (1), .A_WID (7), .D_WID (20), .IN_W (5), .IN_H (3)
    ) u_odd (
        .clk (clk), .rst_n (rst_n), .start (start2), .busy (busy2), .done (done2),
        .ram_ena (ram_ena2), .ram_we (ram_we2), .ram_addr (ram_addr2), .ram_dout (ram_dout2),
        .m_valid (m_valid2), .m_ready (m_ready2), .m_data (m_data2), .m_row (m_row2), .m_col (m_col2)
    );

    // Registered-read RAM models, one cycle of latency.
    always @(posedge clk) begin
        for (int ch = 0; ch < 2; ch++)
            if (ram_ena[ch]) ram_dout[ch] <= mem[ch][ram_addr[ch]];
        if (ram_ena2[0]) ram_dout2[0] <= mem2[ram_addr2[0]];
    end

    task automatic fill_std();
        for (int a = 0; a < 128; a++) begin
            mem[0][a] = signed'(20'(a));
            mem[1][a] = -signed'(20'(a));
            mem2[a]   = signed'(20'(a));
        end
    endtask

    // Runs one pass with m_ready held high and records every accepted output.
    task automatic run_pass(input bit extra);
        int n;
        n_out = 0; done_seen = 0; done_n = -1; first_v_n = -1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (n < 200 && done_seen == 0) begin
            if (m_valid && first_v_n < 0) first_v_n = n;
            if (m_valid && m_ready && n_out < 8) begin
                o_d0[n_out] = m_data[0]; o_d1[n_out] = m_data[1];
                o_row[n_out] = m_row;    o_col[n_out] = m_col;
                n_out++;
            end
            if (done) begin
                done_seen = 1; done_n = n;
            end else begin
                start = extra && (n == 3 || n == 5);
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total_cnt++; if ({busy, done, m_valid} !== 3'b000) $display("FAIL reset_flags got=%b want=000", {busy, done, m_valid}); else pass_cnt++;
        total_cnt++; if ({ram_ena, ram_we} !== 4'b0) $display("FAIL reset_ram got=%b want=0000", {ram_ena, ram_we}); else pass_cnt++;
        total_cnt++; if (ram_addr[0] !== 7'd0 || m_data[0] !== 20'sd0 || m_row !== 1'b0 || m_col !== 1'b0)
            $display("FAIL reset_data addr=%0d data=%0d row=%0d col=%0d want all 0", ram_addr[0], m_data[0], m_row, m_col); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        fill_std();
        run_pass(1'b0);
        total_cnt++; if (n_out !== 4) $display("FAIL basic_count got=%0d want=4", n_out); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (o_d0[i] !== exp0[i]) $display("FAIL basic_ch0[%0d] got=%0d want=%0d", i, o_d0[i], exp0[i]); else pass_cnt++;
            total_cnt++; if (o_d1[i] !== exp1[i]) $display("FAIL basic_ch1[%0d] got=%0d want=%0d", i, o_d1[i], exp1[i]); else pass_cnt++;
            total_cnt++; if (o_row[i] !== 1'(exp_r[i]) || o_col[i] !== 1'(exp_c[i]))
                $display("FAIL basic_pos[%0d] got=(%0d,%0d) want=(%0d,%0d)", i, o_row[i], o_col[i], exp_r[i], exp_c[i]); else pass_cnt++;
        end
        total_cnt++; if (first_v_n !== 5) $display("FAIL basic_latency got=%0d want=5", first_v_n); else pass_cnt++;
        total_cnt++; if (done_n !== 24) $display("FAIL basic_pass_len got=%0d want=24", done_n); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (done !== 1'b0 || busy !== 1'b0) $display("FAIL basic_done_pulse done=%b busy=%b want 0 0", done, busy); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int bad;
        fill_std();
        mem[0][0] = 20'sd77;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total_cnt++; if (ram_ena !== 2'b11 || ram_addr[0] !== 7'd4 || m_data[0] !== 20'sd77)
            $display("FAIL rstmid_pre ena=%b addr=%0d acc=%0d want 11 4 77", ram_ena, ram_addr[0], m_data[0]); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++; if (busy !== 1'b0 || ram_ena !== 2'b00 || ram_addr[0] !== 7'd0 || m_data[0] !== 20'sd0 || m_valid !== 1'b0)
            $display("FAIL rstmid_async busy=%b ena=%b addr=%0d data=%0d valid=%b want all 0", busy, ram_ena, ram_addr[0], m_data[0], m_valid); else pass_cnt++;
        @(negedge clk); rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (done || busy) bad++;
        end
        total_cnt++; if (bad !== 0) $display("FAIL rstmid_quiet got=%0d busy/done cycles want=0", bad); else pass_cnt++;
        fill_std();
        run_pass(1'b0);
        total_cnt++; if (n_out !== 4 || done_n !== 24) $display("FAIL rstmid_rerun outs=%0d len=%0d want 4 24", n_out, done_n); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (o_d0[i] !== exp0[i]) $display("FAIL rstmid_ch0[%0d] got=%0d want=%0d", i, o_d0[i], exp0[i]); else pass_cnt++;
        end
    endtask

    task automatic test_signed();
        fill_std();
        mem[0][0] = -20'sd524288; mem[0][1] = -20'sd1; mem[0][4] = -20'sd524288; mem[0][5] = -20'sd2;
        mem[0][2] = -20'sd524288; mem[0][3] = -20'sd524288; mem[0][6] = -20'sd524288; mem[0][7] = -20'sd524288;
        mem[1][0] = -20'sd5; mem[1][1] = 20'sd7; mem[1][4] = 20'sd524287; mem[1][5] = -20'sd524288;
        run_pass(1'b0);
        total_cnt++; if (o_d0[0] !== -20'sd1) $display("FAIL signed_mixed got=%0d want=-1", o_d0[0]); else pass_cnt++;
        total_cnt++; if (o_d0[1] !== -20'sd524288) $display("FAIL signed_allmin got=%0d want=-524288", o_d0[1]); else pass_cnt++;
        total_cnt++; if (o_d1[0] !== 20'sd524287) $display("FAIL signed_max got=%0d want=524287", o_d1[0]); else pass_cnt++;
        total_cnt++; if (o_d0[2] !== 20'sd13) $display("FAIL signed_untouched got=%0d want=13", o_d0[2]); else pass_cnt++;
        fill_std();
    endtask

    task automatic test_backpressure();
        int n, bad, got;
        logic signed [19:0] last;
        fill_std();
        m_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!m_valid && n < 20) begin
            @(negedge clk); n++;
        end
        total_cnt++; if (m_valid !== 1'b1) $display("FAIL bp_valid_timeout got=%b want=1", m_valid); else pass_cnt++;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid !== 1'b1 || m_data[0] !== 20'sd5 || m_data[1] !== 20'sd0 || ram_ena !== 2'b00) bad++;
            @(negedge clk);
        end
        total_cnt++; if (bad !== 0) $display("FAIL bp_hold got=%0d bad cycles want=0", bad); else pass_cnt++;
        m_ready = 1'b1;
        @(negedge clk);
        total_cnt++; if (ram_ena !== 2'b11 || ram_addr[0] !== 7'd2 || m_valid !== 1'b0)
            $display("FAIL bp_resume ena=%b addr=%0d valid=%b want 11 2 0", ram_ena, ram_addr[0], m_valid); else pass_cnt++;
        got = 0; last = '0; n = 0;
        while (!done && n < 100) begin
            if (m_valid) begin got++; last = m_data[0]; end
            @(negedge clk); n++;
        end
        total_cnt++; if (got !== 3 || last !== 20'sd15 || done !== 1'b1)
            $display("FAIL bp_rest outs=%0d last=%0d done=%b want 3 15 1", got, last, done); else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic signed [19:0] s_d0 [4];
        logic signed [19:0] s_d1 [4];
        int len1, outs1;
        fill_std();
        run_pass(1'b1);
        len1 = done_n; outs1 = n_out;
        for (int i = 0; i < 4; i++) begin s_d0[i] = o_d0[i]; s_d1[i] = o_d1[i]; end
        total_cnt++; if (len1 !== 24 || outs1 !== 4) $display("FAIL b2b_first len=%0d outs=%0d want 24 4", len1, outs1); else pass_cnt++;
        total_cnt++; if (s_d0[3] !== 20'sd15 || s_d1[3] !== -20'sd10) $display("FAIL b2b_first_last got=%0d,%0d want 15,-10", s_d0[3], s_d1[3]); else pass_cnt++;
        run_pass(1'b0);
        total_cnt++; if (done_n !== 24 || n_out !== 4 || first_v_n !== 5)
            $display("FAIL b2b_second len=%0d outs=%0d lat=%0d want 24 4 5", done_n, n_out, first_v_n); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if (o_d0[i] !== s_d0[i] || o_d1[i] !== s_d1[i] || o_d0[i] !== exp0[i])
                $display("FAIL b2b_same[%0d] got=%0d,%0d want=%0d,%0d", i, o_d0[i], o_d1[i], exp0[i], exp1[i]); else pass_cnt++;
        end
    endtask

    task automatic test_odd();
        int n, reads, bad, outs;
        logic signed [19:0] v [2];
        logic [0:0] cc [2];
        logic [0:0] rr [2];
        fill_std();
        reads = 0; bad = 0; outs = 0; n = 0;
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        while (!done2 && n < 100) begin
            if (ram_ena2[0]) begin
                reads++;
                if (ram_addr2[0] == 7'd4 || ram_addr2[0] == 7'd9 || (ram_addr2[0] >= 7'd10 && ram_addr2[0] <= 7'd14)) bad++;
            end
            if (ram_we2 !== 1'b0) bad++;
            if (m_valid2 && outs < 2) begin v[outs] = m_data2[0]; rr[outs] = m_row2; cc[outs] = m_col2; outs++; end
            @(negedge clk); n++;
        end
        total_cnt++; if (bad !== 0 || reads !== 8) $display("FAIL odd_addr bad=%0d reads=%0d want 0 8", bad, reads); else pass_cnt++;
        total_cnt++; if (outs !== 2 || done2 !== 1'b1 || busy2 !== 1'b0) $display("FAIL odd_count outs=%0d done=%b want 2 1", outs, done2); else pass_cnt++;
        total_cnt++; if (v[0] !== 20'sd6 || v[1] !== 20'sd8) $display("FAIL odd_data got=%0d,%0d want 6,8", v[0], v[1]); else pass_cnt++;
        total_cnt++; if (rr[0] !== 1'b0 || rr[1] !== 1'b0 || cc[0] !== 1'b0 || cc[1] !== 1'b1)
            $display("FAIL odd_pos got=(%0d,%0d)(%0d,%0d) want (0,0)(0,1)", rr[0], cc[0], rr[1], cc[1]); else pass_cnt++;
    endtask

    initial begin
        fill_std();
        test_reset();
        test_basic();
        test_reset_mid();
        test_signed();
        test_backpressure();
        test_back_to_back();
        test_odd();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
